// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: REG_N read/write registers exposed as a flat vector,
// with a one-cycle write pulse per register. AW and W are captured into
// independent one-entry holders, so they may arrive in any order.
module axi4_lite_reg_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_N  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_W-1:0]       AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_W-1:0]       WDATA,
    input  logic [DATA_W/8-1:0]     WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic                    BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_W-1:0]       ARADDR,
    input  logic [2:0]              ARPROT,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_W-1:0]       RDATA,
    output logic                    RRESP,
    output logic [REG_N*DATA_W-1:0] reg_q,
    output logic [REG_N-1:0]        wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(REG_N);

    logic              aw_full;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_full;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              commit;

    logic [ADDR_W-1:0] aw_word;
    logic [ADDR_W-1:0] ar_word;
    logic              aw_in_range;
    logic              ar_in_range;
    logic [IDX_W-1:0]  aw_idx;
    logic [IDX_W-1:0]  ar_idx;

    // Protection attributes carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    assign AWREADY = !aw_full;
    assign WREADY  = !w_full;
    assign ARREADY = !RVALID;

    // A write retires only once both halves are held and the B slot is free.
    assign commit = aw_full && w_full && !BVALID;

    assign aw_word     = aw_addr_q >> OFS;
    assign aw_in_range = aw_word < ADDR_W'(REG_N);
    assign aw_idx      = aw_word[IDX_W-1:0];

    assign ar_word     = ARADDR >> OFS;
    assign ar_in_range = ar_word < ADDR_W'(REG_N);
    assign ar_idx      = ar_word[IDX_W-1:0];

    // Write address holder: fill on AW handshake, drain on commit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
        end else if (AWVALID && AWREADY) begin
            aw_full   <= 1'b1;
            aw_addr_q <= AWADDR;
        end else if (commit) begin
            aw_full   <= 1'b0;
        end
    end

    // Write data holder: fill on W handshake, drain on commit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (WVALID && WREADY) begin
            w_full   <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
        end else if (commit) begin
            w_full   <= 1'b0;
        end
    end

    // Write response: raised by commit, dropped on B handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BVALID <= 1'b0;
            BRESP  <= 1'b0;
        end else if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= !aw_in_range;
        end else if (BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Register bank update (byte-lane merge) and per-register write pulse.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            reg_q    <= '0;
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                wr_pulse[i] <= commit && aw_in_range && (aw_idx == IDX_W'(i));
                for (int k = 0; k < STRB_W; k++) begin
                    if (commit && aw_in_range && (aw_idx == IDX_W'(i)) && w_strb_q[k]) begin
                        reg_q[i*DATA_W + k*8 +: 8] <= w_data_q[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Read channel: capture on AR handshake, hold until R handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= 1'b0;
        end else if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RRESP  <= !ar_in_range;
            RDATA  <= ar_in_range ? reg_q[int'(ar_idx)*DATA_W +: DATA_W] : '0;
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Scoreboard bench for axi4_lite_reg_slave: stimulus pushes expected B/R
// responses computed from an array model; a monitor pops and compares.
module tb_axi4_lite_reg_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_N  = 16;
    localparam int W      = REG_N * DATA_W;

    typedef logic [W-1:0] wide_t;
    typedef struct {
        logic             resp;
        logic [REG_N-1:0] pulse;
        wide_t            regs;
    } b_exp_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              resp;
    } r_exp_t;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, BRESP;
    logic              ARVALID, ARREADY, RVALID, RREADY, RRESP;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [3:0]        WSTRB;
    wide_t             reg_q;
    logic [REG_N-1:0]  wr_pulse;

    axi4_lite_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_N(REG_N)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_hs = 0;
    int b_rise_cyc = -1;

    always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

    b_exp_t            bq[$];
    r_exp_t            rq[$];
    logic [DATA_W-1:0] mdl[REG_N];

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected response", nm);
    endtask

    function automatic wide_t mdl_flat();
        wide_t f;
        for (int i = 0; i < REG_N; i++) f[i*DATA_W +: DATA_W] = mdl[i];
        return f;
    endfunction

    // ---------------- monitor ----------------
    logic              b_prev = 1'b0, bready_prev = 1'b0, bresp_prev = 1'b0;
    logic              r_prev = 1'b0, rready_prev = 1'b0, rresp_prev = 1'b0;
    logic [DATA_W-1:0] rdata_prev = '0;
    b_exp_t            mb;
    r_exp_t            mr;

    initial begin
        forever begin
            @(negedge ACLK);
            #1;
            if (!ARESETn) begin
                b_prev = 1'b0;
                r_prev = 1'b0;
            end else begin
                if (b_prev && !bready_prev) begin
                    chk("b_hold_valid", wide_t'(BVALID), wide_t'(1'b1));
                    chk("b_hold_resp", wide_t'(BRESP), wide_t'(bresp_prev));
                    chk("wr_pulse_stall", wide_t'(wr_pulse), '0);
                end else if (BVALID) begin
                    b_rise_cyc = cyc_cnt;
                    if (bq.size() == 0) begin
                        fail_now("b_unexpected");
                    end else begin
                        mb = bq.pop_front();
                        chk("bresp", wide_t'(BRESP), wide_t'(mb.resp));
                        chk("wr_pulse", wide_t'(wr_pulse), wide_t'(mb.pulse));
                        chk("reg_q", reg_q, mb.regs);
                    end
                end else begin
                    chk("wr_pulse_idle", wide_t'(wr_pulse), '0);
                end

                if (r_prev && !rready_prev) begin
                    chk("r_hold_valid", wide_t'(RVALID), wide_t'(1'b1));
                    chk("r_hold_data", wide_t'(RDATA), wide_t'(rdata_prev));
                    chk("r_hold_resp", wide_t'(RRESP), wide_t'(rresp_prev));
                    chk("arready_stall", wide_t'(ARREADY), '0);
                end
                if (RVALID && RREADY) begin
                    if (rq.size() == 0) begin
                        fail_now("r_unexpected");
                    end else begin
                        mr = rq.pop_front();
                        chk("rdata", wide_t'(RDATA), wide_t'(mr.data));
                        chk("rresp", wide_t'(RRESP), wide_t'(mr.resp));
                    end
                end
                b_prev      = BVALID;
                bready_prev = BREADY;
                bresp_prev  = BRESP;
                r_prev      = RVALID;
                rready_prev = RREADY;
                rresp_prev  = RRESP;
                rdata_prev  = RDATA;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        b_exp_t e;
        int     idx;
        int     n;
        bit     aw_go, w_go, aw_done, w_done;
        idx = int'(addr >> 2);
        e.pulse = '0;
        e.resp  = (idx >= REG_N);
        if (idx < REG_N) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) mdl[idx][k*8 +: 8] = data[k*8 +: 8];
            e.pulse[idx] = 1'b1;
        end
        e.regs = mdl_flat();
        bq.push_back(e);
        aw_go = 0; w_go = 0; aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            n++;
            if (n > 60) begin
                fail_now("write_handshake");
                AWVALID = 0;
                WVALID  = 0;
                return;
            end
            if (aw_go) begin AWVALID = 0; aw_go = 0; aw_done = 1; end
            if (w_go)  begin WVALID = 0;  w_go = 0;  w_done = 1;  end
            if (w_done && !aw_done) begin
                chk("wready_held", wide_t'(WREADY), '0);
                chk("awready_open", wide_t'(AWREADY), wide_t'(1'b1));
            end
            if (aw_done && !w_done) begin
                chk("awready_held", wide_t'(AWREADY), '0);
                chk("wready_open", wide_t'(WREADY), wide_t'(1'b1));
            end
            if (!aw_done && !aw_go && n > aw_dly) begin
                AWVALID = 1; AWADDR = addr; AWPROT = 3'($urandom);
            end
            if (!w_done && !w_go && n > w_dly) begin
                WVALID = 1; WDATA = data; WSTRB = strb;
            end
            if (AWVALID && AWREADY && !aw_go && !aw_done) begin aw_go = 1; last_hs = cyc_cnt; end
            if (WVALID && WREADY && !w_go && !w_done)     begin w_go = 1;  last_hs = cyc_cnt; end
        end
        chk("awready_full", wide_t'(AWREADY), '0);
        chk("wready_full", wide_t'(WREADY), '0);
    endtask

    task automatic wait_b(input bit rnd);
        int n;
        n = 0;
        forever begin
            @(negedge ACLK);
            n++;
            BREADY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (BVALID && BREADY) break;
            if (n > 60) begin fail_now("b_wait"); return; end
        end
        @(negedge ACLK);
        chk("b_latency", wide_t'(b_rise_cyc - last_hs), wide_t'(2));
    endtask

    task automatic do_read(input logic [31:0] addr);
        r_exp_t e;
        int     idx;
        int     n;
        idx = int'(addr >> 2);
        e.resp = (idx >= REG_N);
        e.data = (idx < REG_N) ? mdl[idx] : '0;
        rq.push_back(e);
        @(negedge ACLK);
        ARVALID = 1; ARADDR = addr; ARPROT = 3'($urandom);
        n = 0;
        while (!ARREADY) begin
            @(negedge ACLK);
            n++;
            if (n > 60) begin fail_now("ar_wait"); ARVALID = 0; return; end
        end
        @(negedge ACLK);
        ARVALID = 0;
        chk("rvalid_latency", wide_t'(RVALID), wide_t'(1'b1));
    endtask

    task automatic wait_r(input bit rnd);
        int n;
        n = 0;
        forever begin
            if (RVALID && RREADY) break;
            @(negedge ACLK);
            n++;
            RREADY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (n > 60) begin fail_now("r_wait"); return; end
        end
        @(negedge ACLK);
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        while (!BVALID) begin
            @(negedge ACLK);
            n++;
            if (n > 60) begin fail_now("bvalid_wait"); return; end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WDATA = '0; WSTRB = '0;
        for (int i = 0; i < REG_N; i++) mdl[i] = '0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);
        chk("rst_awready", wide_t'(AWREADY), wide_t'(1'b1));
        chk("rst_wready", wide_t'(WREADY), wide_t'(1'b1));
        chk("rst_arready", wide_t'(ARREADY), wide_t'(1'b1));
        chk("rst_bvalid", wide_t'(BVALID), '0);
        chk("rst_rvalid", wide_t'(RVALID), '0);
        chk("rst_reg_q", reg_q, '0);
        do_read(32'h0C); wait_r(0);

        // aligned write then read back
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0); wait_b(0);
        chk("reg2_full", wide_t'(reg_q[95:64]), wide_t'(32'hDEADBEEF));
        do_read(32'h08); wait_r(0);

        // data before address, partial strobe
        do_write(32'h08, 32'h11223344, 4'h5, 3, 0); wait_b(0);
        chk("reg2_merge", wide_t'(reg_q[95:64]), wide_t'(32'hDE22BE44));
        do_read(32'h08); wait_r(0);

        // out of range
        do_write(32'h40, 32'h12345678, 4'hF, 0, 0); wait_b(0);
        do_read(32'h40); wait_r(0);

        // B backpressure with a second pair parked in the holders
        BREADY = 0;
        do_write(32'h04, $urandom, 4'hF, 0, 0);
        wait_bvalid();
        do_write(32'h10, $urandom, 4'hF, 1, 0);
        repeat (5) begin
            @(negedge ACLK);
            chk("stall_awready", wide_t'(AWREADY), '0);
            chk("stall_wready", wide_t'(WREADY), '0);
        end
        @(negedge ACLK);
        BREADY = 1;
        c = cyc_cnt;
        repeat (3) @(negedge ACLK);
        chk("commit_after_b", wide_t'(b_rise_cyc), wide_t'(c + 2));

        // R backpressure
        RREADY = 0;
        do_read(32'h10);
        repeat (5) @(negedge ACLK);
        RREADY = 1;
        repeat (2) @(negedge ACLK);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(32'($urandom_range(0, REG_N + 3) * 4 + $urandom_range(0, 3)),
                         $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b(1);
            end else begin
                do_read(32'($urandom_range(0, REG_N + 3) * 4 + $urandom_range(0, 3)));
                wait_r(1);
            end
        end
        BREADY = 1; RREADY = 1;

        // reset while a response is pending and the address holder is full
        BREADY = 0;
        do_write(32'h0C, 32'hA5A5_5A5A, 4'hF, 0, 0);
        wait_bvalid();
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'h14;
        @(negedge ACLK);
        AWVALID = 0;
        #2 ARESETn = 0;
        #1;
        chk("arst_bvalid", wide_t'(BVALID), '0);
        chk("arst_reg_q", reg_q, '0);
        chk("arst_awready", wide_t'(AWREADY), wide_t'(1'b1));
        bq.delete();
        rq.delete();
        for (int i = 0; i < REG_N; i++) mdl[i] = '0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        BREADY = 1;
        repeat (10) begin
            @(negedge ACLK);
            chk("no_stale_b", wide_t'(BVALID), '0);
        end
        do_read(32'h0C); wait_r(0);

        repeat (3) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite responder presenting a bank of REG_N read/write control registers to an AXI4-Lite master, typically a CPU or bridge. It sits at the slave end of `axi4_lite_if`. Register contents drive design logic through a flat output vector, and per-register write pulses notify that logic of updates. Write address and write data are captured independently, so the block accepts them in any order.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width; 32 or 64.
- REG_N, 16: number of registers; power of two, 2..256.
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- s  modport  `axi4_lite_if.slave`  AXI4-Lite slave side.
  - AWVALID/AWREADY/AWADDR/AWPROT: write address channel.
  - WVALID/WREADY/WDATA/WSTRB: write data channel.
  - BVALID/BREADY/BRESP: write response channel.
  - ARVALID/ARREADY/ARADDR/ARPROT: read address channel.
  - RVALID/RREADY/RDATA/RRESP: read data channel.
- reg_q  out  REG_N*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse  out  REG_N  one-cycle pulse per register written.

## Operation
- Addressing:
  - OFS = log2(DATA_W/8).
  - Register index = ADDR >> OFS; the low OFS bits are ignored.
  - An index >= REG_N is out of range.
  - AWPROT and ARPROT are ignored.
- Response code: BRESP/RRESP are 1 bit; 0 = OKAY, 1 = SLVERR (out of range).
- Write path:
  - One-entry holders aw_full (address) and w_full (data + strobe).
  - AWREADY = !aw_full; WREADY = !w_full. Both are combinational from holder state only.
  - Commit condition: aw_full && w_full && !BVALID.
  - On commit, each byte lane k with WSTRB[k]=1 is written to the indexed register.
  - Also on commit: BVALID set, BRESP set (0 or 1), both holders cleared, wr_pulse[index] set for one cycle.
  - Out-of-range write: no register changes, no wr_pulse, BRESP=1.
  - WSTRB=0 in range: no data change, but wr_pulse still fires and BRESP=0.
  - BVALID clears on BVALID && BREADY.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake: RDATA = indexed register (0 if out of range), RRESP = out-of-range flag, RVALID set.
  - RDATA/RRESP are held stable while RVALID && !RREADY.
  - RVALID clears on RVALID && RREADY.
- Read and write paths are independent. On a same-edge read and commit to the same register, the read returns the old value.
- Reset (asynchronous, any time):
  - reg_q = 0, wr_pulse = 0, holders empty.
  - BVALID = 0, RVALID = 0, BRESP = 0, RRESP = 0, RDATA = 0.
  - In-flight transactions are dropped with no response.
  - After release: AWREADY, WREADY and ARREADY are 1 in the first cycle.

## Timing
- Write, AW and W handshaken together in cycle T:
  - Holders full in T+1; AWREADY and WREADY are 0 in T+1.
  - Commit at the end of T+1.
  - In T+2: new reg_q value visible, wr_pulse high, BVALID high, AWREADY and WREADY high again.
- Write, W handshaken k cycles after AW: commit occurs in the cycle after the later handshake.
- Write throughput: with BREADY held high, one write per 2 cycles.
- BVALID stall: while BVALID=1 and BREADY=0, a full pair of holders waits. Commit happens in the cycle after the B handshake.
- Read: AR handshake in T; RVALID and RDATA valid in T+1. With RREADY held high, one read per 2 cycles.
- Outputs are registered, except AWREADY, WREADY and ARREADY, which decode directly from flops.

## Test plan
- Reset release:
  - Stimulus: release reset.
  - Required: AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, reg_q all zero. Read of addr 0x0C returns 0x00000000 with RRESP=0.
- Write then read:
  - Stimulus: AW 0x08 and W 0xDEADBEEF, WSTRB=0xF, in the same cycle, BREADY=1.
  - Required: BVALID two cycles later with BRESP=0; wr_pulse[2] for one cycle; reg_q[95:64]=0xDEADBEEF. Read 0x08 returns 0xDEADBEEF.
- Reordered partial write:
  - Stimulus: W 0x11223344 with WSTRB=0x5 first, AW 0x08 three cycles later; register 2 preloaded with 0xDEADBEEF.
  - Required: AWREADY stays 1 and WREADY stays 0 until commit; register becomes 0xDE22BE44.
- Out of range (REG_N=16):
  - Stimulus: write 0x40 with 0x12345678.
  - Required: BRESP=1, no wr_pulse, reg_q unchanged. Read 0x40 returns RDATA=0 with RRESP=1.
- Backpressure:
  - Stimulus: BREADY=0 for 5 cycles while a second AW/W pair is issued.
  - Required: BVALID and BRESP stable; second pair held in the holders; second commit in the cycle after B handshake. Same check with RREADY=0: RDATA stable, ARREADY=0.
- Reset mid-operation:
  - Stimulus: assert ARESETn=0 while BVALID=1 and aw_full=1.
  - Required: BVALID=0 immediately (asynchronous), all registers 0, no stale response after release.
